// File: rtl/bscan_spi_readback_packer.sv
// Packs the qualified MISO stream MSB-first into bytes, keeps a CRC-16 and byte count per frame,
// and serialises {byte_count, crc} as a 32-bit trailer on tdo once the frame has closed.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for frame_start, samples ignored
// COLLECT | shifting valid MISO bits into bytes, updating CRC
// FLUSH   | padding the partial last byte with zeros
// TRAILER | trailer loaded, shifted out on trailer_shift
module bscan_spi_readback_packer #(
   parameter logic [15:0] CRC_INIT = 16'hFFFF,
   parameter logic [15:0] CRC_POLY = 16'h1021
) (
   input  logic        DRCK1,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        bit_valid,
   input  logic        miso,
   input  logic        frame_end,
   input  logic        trailer_shift,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic [15:0] byte_count,
   output logic [15:0] crc,
   output logic        tdo,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, TRAILER} state_t;

   state_t      state;
   logic [6:0]  sr;
   logic [2:0]  idx;
   logic [31:0] trailer_sr;

   logic        step_bit;
   logic        fb;
   logic [15:0] crc_next;
   logic [15:0] count_next;
   logic        byte_last;

   // FLUSH pads with zeros, so the shared bit step sees 0 there
   assign step_bit   = (state == COLLECT) ? miso : 1'b0;
   assign fb         = crc[15] ^ step_bit;
   assign crc_next   = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   assign count_next = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
   assign byte_last  = (idx == 3'd7);
   assign tdo        = trailer_sr[31];

   always_ff @(posedge DRCK1 or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         idx        <= '0;
         trailer_sr <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         byte_count <= '0;
         crc        <= CRC_INIT;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (frame_start) begin
            state      <= COLLECT;
            sr         <= '0;
            idx        <= '0;
            trailer_sr <= '0;
            byte_count <= '0;
            crc        <= CRC_INIT;
            done       <= 1'b0;
            overrun    <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               COLLECT: begin
                  if (bit_valid) begin
                     crc <= crc_next;
                     sr  <= {sr[5:0], miso};
                     idx <= idx + 3'd1;
                     if (byte_last) begin
                        byte_data  <= {sr, miso};
                        byte_valid <= 1'b1;
                        byte_count <= count_next;
                     end
                  end
                  // a coincident bit is consumed first, so decide on the post-bit index
                  if (frame_end) begin
                     if (bit_valid ? byte_last : (idx == 3'd0)) begin
                        state      <= TRAILER;
                        done       <= 1'b1;
                        trailer_sr <= bit_valid ? {count_next, crc_next} : {byte_count, crc};
                     end else begin
                        state <= FLUSH;
                     end
                  end
               end
               FLUSH: begin
                  if (bit_valid) overrun <= 1'b1;
                  crc <= crc_next;
                  sr  <= {sr[5:0], 1'b0};
                  idx <= idx + 3'd1;
                  if (byte_last) begin
                     byte_data  <= {sr, 1'b0};
                     byte_valid <= 1'b1;
                     byte_count <= count_next;
                     state      <= TRAILER;
                     done       <= 1'b1;
                     trailer_sr <= {count_next, crc_next};
                  end
               end
               TRAILER: begin
                  if (bit_valid) overrun <= 1'b1;
                  if (trailer_shift) trailer_sr <= {trailer_sr[30:0], 1'b0};
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bscan_spi_readback_packer.sv
// Directed bench for the readback packer: byte packing, CRC, flush padding, trailer shifting,
// overrun, restart, async reset and count saturation.
module tb_bscan_spi_readback_packer;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        bit_valid = 1'b0;
   logic        miso = 1'b0;
   logic        frame_end = 1'b0;
   logic        trailer_shift = 1'b0;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic [15:0] byte_count;
   logic [15:0] crc;
   logic        tdo;
   logic        done;
   logic        overrun;

   int vectors = 0;
   int miscompares = 0;
   int nbv = 0;

   bscan_spi_readback_packer dut (
      .DRCK1(clk_sys), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
      .miso(miso), .frame_end(frame_end), .trailer_shift(trailer_shift),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_count(byte_count),
      .crc(crc), .tdo(tdo), .done(done), .overrun(overrun)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (byte_valid) nbv++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, expected run to complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic fe);
      bit_valid = 1'b1;
      miso      = b;
      frame_end = fe;
      tick();
      bit_valid = 1'b0;
      miso      = 1'b0;
      frame_end = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
   endtask

   task automatic read_trailer(output logic [31:0] t);
      for (int i = 31; i >= 0; i--) begin
         t[i] = tdo;
         trailer_shift = 1'b1;
         tick();
      end
      trailer_shift = 1'b0;
   endtask

   initial begin
      logic [7:0]  msg [9];
      logic [15:0] m_crc;
      logic [31:0] tr;
      int          n;
      int          nbv_snap;

      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

      // reset and idle
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_byte_data", 32'(byte_data), 32'h0);
      chk("rst_crc", 32'(crc), 32'hFFFF);
      chk("rst_flags", {byte_valid, tdo, done, overrun}, 4'b0000);
      for (int i = 0; i < 20; i++) send_bit(i[0], 1'b0);
      tick();
      chk("idle_no_bv", nbv, 0);
      chk("idle_state", {overrun, done, byte_count, crc}, {2'b00, 16'h0000, 16'hFFFF});

      // aligned frame "123456789"
      pulse_start();
      for (int k = 0; k < 9; k++) begin
         send_byte(msg[k]);
         chk("al_byte", {byte_valid, byte_data}, {1'b1, msg[k]});
      end
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      chk("al_done", 32'(done), 32'h1);
      chk("al_count", 32'(byte_count), 32'd9);
      chk("al_crc", 32'(crc), 32'h29B1);
      chk("al_nbv", nbv, 9);
      read_trailer(tr);
      chk("al_trailer", tr, 32'h000929B1);
      chk("al_tdo_after", 32'(tdo), 32'h0);

      // partial byte 1,0,1 -> padded to 0xA0
      pulse_start();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("pb_flush_cycles", n, 5);
      chk("pb_byte", {byte_valid, byte_data}, {1'b1, 8'hA0});
      chk("pb_count", 32'(byte_count), 32'd1);
      m_crc = crc_upd(16'hFFFF, 8'hA0);
      chk("pb_crc", 32'(crc), 32'(m_crc));
      chk("pb_tdo_first", 32'(tdo), 32'h0);

      // 8th bit coincident with frame_end, then a late bit in TRAILER
      pulse_start();
      for (int i = 7; i >= 1; i--) send_bit(8'h5A >> i, 1'b0);
      send_bit(1'b0, 1'b1);
      m_crc = crc_upd(16'hFFFF, 8'h5A);
      chk("co_byte", {byte_valid, byte_data}, {1'b1, 8'h5A});
      chk("co_done_direct", 32'(done), 32'h1);
      chk("co_no_ovr", 32'(overrun), 32'h0);
      send_bit(1'b1, 1'b0);
      chk("co_overrun", 32'(overrun), 32'h1);
      chk("co_state_kept", {byte_count, crc}, {16'd1, m_crc});
      read_trailer(tr);
      chk("co_trailer", tr, {16'd1, m_crc});

      // restart after 12 bits clears everything, overrun included
      pulse_start();
      chk("rs_ovr_clear", 32'(overrun), 32'h0);
      send_byte(8'hC3);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      pulse_start();
      nbv_snap = nbv;
      tick();
      chk("rs_cleared", {done, byte_count, crc}, {1'b0, 16'h0000, 16'hFFFF});
      chk("rs_no_stray_bv", nbv, nbv_snap);
      send_byte(8'h81);
      chk("rs_realigned", {byte_valid, byte_data, byte_count}, {1'b1, 8'h81, 16'd1});

      // async reset during FLUSH
      pulse_start();
      send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      tick();
      nbv_snap = nbv;
      rst = 1'b1;
      #1;
      chk("ar_immediate", {done, byte_count, crc}, {1'b0, 16'h0000, 16'hFFFF});
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("ar_no_trailer", {done, tdo, overrun}, 3'b000);
      chk("ar_no_bv", nbv, nbv_snap);

      // saturation: preload the counter near the top, then keep streaming bytes
      pulse_start();
      force dut.byte_count = 16'hFFFD;
      #1;
      release dut.byte_count;
      m_crc = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         send_byte(8'hF0 + 8'(k));
         m_crc = crc_upd(m_crc, 8'hF0 + 8'(k));
         chk("sat_count", 32'(byte_count), (k == 0) ? 32'hFFFE : 32'hFFFF);
      end
      chk("sat_crc", 32'(crc), 32'(m_crc));
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      read_trailer(tr);
      chk("sat_trailer", tr, {16'hFFFF, m_crc});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
